// File: rtl/adpll_lock_detect.sv
// adpll_lock_detect
// -----------------------------------------------------------------------------
// Lock detector for the ring ADPLL. It takes one phase-error sample per
// reference-clock rising edge and decides whether the loop is locked. Lock
// needs a run of LOCK_COUNT in-window samples. Lock is dropped only after a
// run of UNLOCK_COUNT out-of-window samples, which gives hysteresis.
//
// Ports
//   fpga_clk_i   : the single clock; all state changes on its rising edge
//   reset_i      : asynchronous, active-high reset
//   enable_i     : detector enable; low forces IDLE on the next edge
//   ref_clk_i    : reference clock, asynchronous; one sample per rising edge
//   error_i      : signed phase error, synchronous to fpga_clk_i
//   locked_o     : lock flag, high in LOCKED and HOLD
//   lost_lock_o  : one-cycle pulse when lock is lost (entry to ACQUIRE)
//   state_o      : FSM state (0 IDLE, 1 ACQUIRE, 2 LOCKED, 3 HOLD)
//   abs_error_o  : |error_i| captured at the last sample
//   peak_error_o : max |error| since the last entry to LOCKED
// -----------------------------------------------------------------------------
module adpll_lock_detect #(
    parameter int ERROR_WIDTH  = 5,
    parameter int LOCK_THRESH  = 2,
    parameter int LOCK_COUNT   = 64,
    parameter int UNLOCK_COUNT = 4,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                          fpga_clk_i,
    input  logic                          reset_i,
    input  logic                          enable_i,
    input  logic                          ref_clk_i,
    input  logic signed [ERROR_WIDTH-1:0] error_i,
    output logic                          locked_o,
    output logic                          lost_lock_o,
    output logic        [1:0]             state_o,
    output logic        [ERROR_WIDTH-1:0] abs_error_o,
    output logic        [ERROR_WIDTH-1:0] peak_error_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t                 state, state_next;
    logic [CNT_WIDTH-1:0]   good_cnt, good_next;
    logic [CNT_WIDTH-1:0]   bad_cnt, bad_next;
    logic [ERROR_WIDTH-1:0] peak_next;
    logic                   lost_next;

    // Reference edge detection: two synchroniser flops plus one edge flop.
    logic sync1, sync2, sync3;
    logic stb;

    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= ref_clk_i;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign stb = sync2 & ~sync3;

    // Magnitude in ERROR_WIDTH unsigned bits. The two's-complement negation of
    // the most negative value is 2^(W-1), which is exactly representable here.
    logic [ERROR_WIDTH-1:0] err_u;
    logic [ERROR_WIDTH-1:0] abs_err;
    logic [ERROR_WIDTH-1:0] peak_max;
    logic                   in_window;

    assign err_u     = error_i;
    assign abs_err   = err_u[ERROR_WIDTH-1] ? ERROR_WIDTH'(~err_u + 1'b1) : err_u;
    assign in_window = (abs_err <= ERROR_WIDTH'(LOCK_THRESH));
    assign peak_max  = (abs_err > peak_error_o) ? abs_err : peak_error_o;

    // The counters compare against count-1 so the transition fires on the
    // sample that reaches the count, and the counter is cleared on that same
    // edge. This means it never has to hold the terminal value.
    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        bad_next   = bad_cnt;
        peak_next  = peak_error_o;
        lost_next  = 1'b0;

        if (!enable_i) begin
            // Disable wins over a simultaneous strobe and never signals lost lock.
            state_next = IDLE;
            good_next  = '0;
            bad_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_next = ACQUIRE;
                    good_next  = '0;
                    bad_next   = '0;
                end
                ACQUIRE: begin
                    if (stb) begin
                        if (in_window) begin
                            if (good_cnt == CNT_WIDTH'(LOCK_COUNT - 1)) begin
                                state_next = LOCKED;
                                good_next  = '0;
                                peak_next  = abs_err;
                            end else begin
                                good_next = good_cnt + 1'b1;
                            end
                        end else begin
                            good_next = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (stb) begin
                        peak_next = peak_max;
                        if (!in_window) begin
                            if (UNLOCK_COUNT == 1) begin
                                state_next = ACQUIRE;
                                lost_next  = 1'b1;
                                good_next  = '0;
                                bad_next   = '0;
                            end else begin
                                state_next = HOLD;
                                bad_next   = CNT_WIDTH'(1);
                            end
                        end
                    end
                end
                HOLD: begin
                    if (stb) begin
                        peak_next = peak_max;
                        if (in_window) begin
                            state_next = LOCKED;
                            bad_next   = '0;
                        end else if (bad_cnt == CNT_WIDTH'(UNLOCK_COUNT - 1)) begin
                            state_next = ACQUIRE;
                            lost_next  = 1'b1;
                            good_next  = '0;
                            bad_next   = '0;
                        end else begin
                            bad_next = bad_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    good_next  = '0;
                    bad_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state        <= IDLE;
            good_cnt     <= '0;
            bad_cnt      <= '0;
            locked_o     <= 1'b0;
            lost_lock_o  <= 1'b0;
            abs_error_o  <= '0;
            peak_error_o <= '0;
        end else begin
            state        <= state_next;
            good_cnt     <= good_next;
            bad_cnt      <= bad_next;
            locked_o     <= (state_next == LOCKED) || (state_next == HOLD);
            lost_lock_o  <= lost_next;
            peak_error_o <= peak_next;
            if (stb) begin
                abs_error_o <= abs_err;
            end
        end
    end

    assign state_o = state;

endmodule
